// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed 7-segment scan driver with double-buffered
//            digit data, anti-ghost blank gap, leading-zero blanking and
//            programmable segment/common polarity.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic                    seg_pol,
    input  logic                    com_pol,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   com,
    output logic [NUM_DIGITS-1:0]   com_oe,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4*NUM_DIGITS-1:0] C_BLANK_DIGITS = {NUM_DIGITS{4'hF}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   com_q, com_d, com_oe_q;

    logic                    w_slot_wrap;
    logic                    w_frame;
    logic                    w_gap;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_lz_sel;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [NUM_DIGITS-1:0]   w_com_act;
    logic [7:0]              w_seg_log;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'd0:    f_decode = 7'h3F;
            4'd1:    f_decode = 7'h06;
            4'd2:    f_decode = 7'h5B;
            4'd3:    f_decode = 7'h4F;
            4'd4:    f_decode = 7'h66;
            4'd5:    f_decode = 7'h6D;
            4'd6:    f_decode = 7'h7D;
            4'd7:    f_decode = 7'h07;
            4'd8:    f_decode = 7'h7F;
            4'd9:    f_decode = 7'h6F;
            default: f_decode = 7'h00;
        endcase
    endfunction

    assign w_slot_wrap = (cnt_q == C_CNT_MAX);
    assign w_frame     = w_slot_wrap && (idx_q == C_IDX_MAX);

    // Blank gap only exists when BLANK_CYCLES is non-zero; avoids a constant compare.
    generate
        if (BLANK_CYCLES > 0) begin : g_gap_on
            assign w_gap = (cnt_q < CNT_W'(BLANK_CYCLES));
        end else begin : g_gap_off
            assign w_gap = 1'b0;
        end
    endgenerate

    // Scan counters and shadow/active buffer handoff at the frame boundary.
    always_comb begin
        cnt_d     = w_slot_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        sh_dig_d  = sh_dig_q;
        sh_dp_d   = sh_dp_q;
        act_dig_d = act_dig_q;
        act_dp_d  = act_dp_q;
        pend_d    = pend_q | load;
        if (w_slot_wrap) begin
            idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
        if (load) begin
            sh_dig_d = digits_in;
            sh_dp_d  = dp_in;
        end
        // The shadow is sampled before this cycle's load lands, so a load on
        // the boundary stays pending for the following frame.
        if (w_frame) begin
            if (pend_q) begin
                act_dig_d = sh_dig_q;
                act_dp_d  = sh_dp_q;
            end
            pend_d = load;
        end
    end

    // Select the shown digit, build leading-zero mask and the next output word.
    always_comb begin
        logic all_zero;
        w_nib     = 4'hF;
        w_dp      = 1'b0;
        w_lz_sel  = 1'b0;
        w_lz_mask = '0;
        w_com_act = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (act_dig_q[4*i +: 4] == 4'd0);
            w_lz_mask[i] = all_zero && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_nib        = act_dig_q[4*i +: 4];
                w_dp         = act_dp_q[i];
                w_lz_sel     = w_lz_mask[i];
                w_com_act[i] = !w_gap;
            end
        end
        w_seg_log = {w_dp, (lz_blank && w_lz_sel) ? 7'h00 : f_decode(w_nib)};
        if (w_gap) begin
            w_seg_log = 8'h00;
        end
        seg_d = seg_pol ? w_seg_log : ~w_seg_log;
        com_d = com_pol ? w_com_act : ~w_com_act;
    end

    // State and registered physical outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            act_dig_q <= C_BLANK_DIGITS;
            sh_dig_q  <= C_BLANK_DIGITS;
            act_dp_q  <= '0;
            sh_dp_q   <= '0;
            seg_q     <= seg_pol ? 8'h00 : 8'hFF;
            com_q     <= com_pol ? '0 : '1;
            com_oe_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            act_dig_q <= act_dig_d;
            sh_dig_q  <= sh_dig_d;
            act_dp_q  <= act_dp_d;
            sh_dp_q   <= sh_dp_d;
            seg_q     <= seg_d;
            com_q     <= com_d;
            com_oe_q  <= '1;
        end
    end

    assign seg        = seg_q;
    assign com        = com_q;
    assign com_oe     = com_oe_q;
    assign frame_done = w_frame && !rst;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver (2 digits, 8-cycle
//            slots, 2-cycle blank gap): frame expectations are queued when a
//            load is driven and compared cycle by cycle over the shown frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND = 2;
    localparam int RD = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0] dp_in;
    logic          load, lz_blank, seg_pol, com_pol;
    logic [7:0]    seg;
    logic [ND-1:0] com, com_oe;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [7:0] s0, s1, sg;
        logic [1:0] c0, c1, cg;
    } exp_t;

    typedef struct {
        logic [7:0] digits;
        logic [1:0] dp;
        logic       lz, sp, cp;
        logic [7:0] s0, s1;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .lz_blank(lz_blank), .seg_pol(seg_pol), .com_pol(com_pol),
        .seg(seg), .com(com), .com_oe(com_oe), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input int id, input logic [7:0] s0, input logic [7:0] s1,
                                    input logic sp, input logic cp);
        exp_t e;
        e.id = id;
        e.s0 = s0;
        e.s1 = s1;
        e.sg = sp ? 8'h00 : 8'hFF;
        e.cg = cp ? 2'b00 : 2'b11;
        e.c0 = cp ? 2'b01 : 2'b10;
        e.c1 = cp ? 2'b10 : 2'b01;
        return e;
    endfunction

    task automatic do_load(input logic [7:0] d, input logic [1:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_done not seen within 40 cycles", name);
        end
    endtask

    // Count cycles until frame_done starting from the current negedge.
    task automatic chk_latency(input string name, input int exp_n);
        int n = 0;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 8'(n), 8'(exp_n));
    endtask

    // Called on the negedge where frame_done was seen; compares the frame
    // that begins two cycles later (one cycle of output register lag).
    task automatic observe(input bit skip);
        exp_t e;
        logic [7:0] es;
        logic [1:0] ec;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: empty queue at %0t", $time);
            return;
        end
        e = sb_q.pop_front();
        if (skip) begin
            @(negedge clk);
            load = 1'b0;
        end
        for (int p = 0; p < 2 * RD; p++) begin
            @(negedge clk);
            if ((p % RD) < BC) begin
                es = e.sg;
                ec = e.cg;
            end else if (p < RD) begin
                es = e.s0;
                ec = e.c0;
            end else begin
                es = e.s1;
                ec = e.c1;
            end
            chk($sformatf("seg f%0d p%0d", e.id, p), seg, es);
            chk($sformatf("com f%0d p%0d", e.id, p), {6'b0, com}, {6'b0, ec});
            chk($sformatf("frame_done f%0d p%0d", e.id, p), {7'b0, frame_done},
                {7'b0, (p == 2 * RD - 2)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h42, 2'b00, 1'b0, 1'b1, 1'b1, 8'h5B, 8'h66};
        vecs[1] = '{8'h07, 2'b00, 1'b1, 1'b1, 1'b1, 8'h07, 8'h00};
        vecs[2] = '{8'h07, 2'b00, 1'b0, 1'b1, 1'b1, 8'h07, 8'h3F};
        vecs[3] = '{8'h88, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 8'h3F, 8'h00};
        vecs[5] = '{8'hF5, 2'b10, 1'b1, 1'b1, 1'b1, 8'h6D, 8'h80};
        vecs[6] = '{8'h09, 2'b10, 1'b1, 1'b1, 1'b1, 8'h6F, 8'h80};
        vecs[7] = '{8'h31, 2'b00, 1'b0, 1'b1, 1'b0, 8'h06, 8'h4F};
        vecs[8] = '{8'h56, 2'b01, 1'b0, 1'b1, 1'b1, 8'hFD, 8'h6D};
        vecs[9] = '{8'h2C, 2'b00, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hA4};

        rst = 1'b1; digits_in = '0; dp_in = '0; load = 1'b0;
        lz_blank = 1'b0; seg_pol = 1'b1; com_pol = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst seg", seg, 8'h00);
        chk("rst com", {6'b0, com}, 8'h00);
        chk("rst com_oe", {6'b0, com_oe}, 8'h00);
        chk("rst frame_done", {7'b0, frame_done}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst com_oe", {6'b0, com_oe}, 8'h03);
        chk("post-rst com", {6'b0, com}, 8'h00);
        chk("post-rst seg", seg, 8'h00);
        chk_latency("rst to first frame_done", 14);
        sb_q.push_back(mk_exp(100, 8'h00, 8'h00, 1'b1, 1'b1));
        observe(1'b1);

        // Table-driven vectors.
        for (int v = 0; v < 10; v++) begin
            lz_blank = vecs[v].lz;
            seg_pol  = vecs[v].sp;
            com_pol  = vecs[v].cp;
            do_load(vecs[v].digits, vecs[v].dp);
            sb_q.push_back(mk_exp(v, vecs[v].s0, vecs[v].s1, vecs[v].sp, vecs[v].cp));
            wait_fd($sformatf("vec%0d boundary", v));
            observe(1'b1);
        end

        lz_blank = 1'b0; seg_pol = 1'b1; com_pol = 1'b1;

        // Last load before the boundary wins.
        do_load(8'h12, 2'b00);
        repeat (3) @(negedge clk);
        do_load(8'h34, 2'b00);
        sb_q.push_back(mk_exp(200, 8'h66, 8'h4F, 1'b1, 1'b1));
        wait_fd("overwrite boundary");
        observe(1'b1);

        // Load on the boundary cycle: old pending now, new one frame later.
        do_load(8'h21, 2'b00);
        wait_fd("coincide boundary");
        digits_in = 8'h43;
        dp_in     = 2'b00;
        load      = 1'b1;
        sb_q.push_back(mk_exp(300, 8'h06, 8'h5B, 1'b1, 1'b1));
        observe(1'b1);
        sb_q.push_back(mk_exp(301, 8'h4F, 8'h66, 1'b1, 1'b1));
        observe(1'b0);

        // Mid-slot reset discards pending load and blanks the display.
        do_load(8'h99, 2'b11);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst com", {6'b0, com}, 8'h00);
        chk("midrst seg", seg, 8'h00);
        chk("midrst com_oe", {6'b0, com_oe}, 8'h00);
        chk_latency("midrst to frame_done", 15);
        sb_q.push_back(mk_exp(400, 8'h00, 8'h00, 1'b1, 1'b1));
        observe(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 2, number of multiplexed digits (legal 1..8).
REQ-002 Parameter REFRESH_DIV, default 1000, clock cycles per digit slot (legal 4..65535).
REQ-003 Parameter BLANK_CYCLES, default 2, anti-ghost gap at the start of each slot (legal 0..REFRESH_DIV-2).
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 digits_in  in  4*NUM_DIGITS  BCD nibbles, nibble 0 = least-significant digit.
REQ-008 dp_in  in  NUM_DIGITS  decimal-point request per digit.
REQ-009 load  in  1  one-cycle strobe capturing digits_in/dp_in into the shadow buffer.
REQ-010 lz_blank  in  1  leading-zero blanking enable.
REQ-011 seg_pol  in  1  segment polarity: 1 = lit segment driven high.
REQ-012 com_pol  in  1  common polarity: 1 = active common driven high.
REQ-013 seg  out  8  segments; bit0..6 = a..g, bit7 = dp.
REQ-014 com  out  NUM_DIGITS  digit commons, bit i selects digit i.
REQ-015 com_oe  out  NUM_DIGITS  output enables for com; all ones after reset is released.
REQ-016 frame_done  out  1  one-cycle pulse at the end of each full scan.

Function
REQ-017 Slot counter counts 0..REFRESH_DIV-1 and wraps; on wrap, digit index advances 0..NUM_DIGITS-1, then wraps to 0.
REQ-018 During slot counts 0..BLANK_CYCLES-1, all commons and all segments are inactive.
REQ-019 For the remaining slot counts, only com[index] is active and seg shows the active-buffer digit at index.
REQ-020 Decode (logical, lit=1): 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F; codes 10..15 give 0x00 (blank).
REQ-021 seg[7] lit when the active dp bit for the shown digit is 1, independent of blanking.
REQ-022 With lz_blank=1, a digit is blanked when it and every more-significant digit are 0; digit 0 is never blanked.
REQ-023 Physical out: seg = seg_pol ? logical : ~logical; com bit = com_pol ? active : ~active; inactive bits are the complements.
REQ-024 seg and com are registered and lag counter/index state by one cycle; polarity and lz_blank changes take effect on the next clock.
REQ-025 load writes the shadow buffer; a repeated load before the frame boundary overwrites the shadow (last wins).
REQ-026 The shadow copies into the active buffer only at the frame boundary (index wraps from NUM_DIGITS-1 to 0) when a load is pending; a display never mixes two loads within one scan.
REQ-027 load coinciding with the frame-boundary cycle: the new data enters the shadow and is applied at the next boundary; the previously pending data transfers now.
REQ-028 frame_done pulses high for exactly one cycle, coinciding with the boundary transfer cycle, once every NUM_DIGITS*REFRESH_DIV cycles.
REQ-029 NUM_DIGITS=1: index stays 0, boundary every slot wrap.

Reset
REQ-030 rst=1 at a clock edge: counter=0, index=0, pending=0, active and shadow buffers=all 0xF (blank), dp buffers=0.
REQ-031 During reset and the first output cycle after it, all com bits inactive, all seg bits inactive (per current polarity), frame_done=0, com_oe=0 during reset.
REQ-032 Reset asserted mid-scan aborts the scan immediately; a pending load is discarded.

Verification
REQ-033 NUM_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2, seg_pol=com_pol=1, load 0x42 -> after first boundary, digit0 shows 0x5B for 6 of every 8 cycles, digit1 shows 0x66, frame_done every 16 cycles.
REQ-034 Same setup, load 0x07 with lz_blank=1 -> digit1 seg=0x00, digit0 seg=0x07; lz_blank=0 -> digit1 seg=0x3F.
REQ-035 seg_pol=0, com_pol=0, digit value 8, dp=1 -> seg=0x00 during active cycles, active com bit=0, inactive com=1, blank-gap seg=0xFF.
REQ-036 load 0x12 then load 0x34 mid-scan -> no 0x12 frame ever displayed; first full scan after boundary shows 3/4; never 1/4 or 3/2 within one scan.
REQ-037 load on the boundary cycle -> old pending applied now, new data applied one frame later.
REQ-038 rst pulsed mid-slot -> next cycle all commons inactive, counter 0, display blank until a new load and boundary.
